mac_dot_arbiter: RTL and testbench

Round-robin scheduler that shares one signed 8x8→16 multiply-accumulate unit between two streaming requesters. Each grant covers one whole dot product of `VEC_LEN` element pairs. The arbiter clears the accumulator, forwards the granted requester's operands with a valid/ready handshake, drains the MAC pipeline, and returns the 16-bit result tagged with the requester ID. It sits between the two operand producers and the MAC datapath. The MAC's reset pin is driven by `reset | mac_clr`.

---
 rtl/mac_dot_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_mac_dot_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_dot_arbiter.sv
// mac_dot_arbiter
// Shares one signed 8x8->16 multiply-accumulate unit between two streaming
// requesters. Each grant covers one full dot product of VEC_LEN element pairs:
// the MAC is cleared, operands are forwarded with a valid/ready handshake, the
// MAC pipeline is drained and the accumulator is returned tagged with the
// owning requester.
//
// Build option: MAC_DOT_ARB_FIXED_PRIO_EN
//   defined   - requester 0 always wins ties, no last-granted pointer.
//   undefined - round-robin on ties (default).
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for a request; grant is chosen and registered here
// S_CLEAR | one-cycle MAC clear, both readies low
// S_FEED  | granted requester streams operand pairs into the MAC
// S_DRAIN | all pairs accepted, waiting for the MAC to finish accumulating

module mac_dot_arbiter #(
    parameter int VEC_LEN = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        req0_valid_i,
    input  logic [7:0]  req0_a_i,
    input  logic [7:0]  req0_b_i,
    output logic        req0_ready_o,

    input  logic        req1_valid_i,
    input  logic [7:0]  req1_a_i,
    input  logic [7:0]  req1_b_i,
    output logic        req1_ready_o,

    output logic        mac_clr_o,
    output logic [7:0]  mac_a_o,
    output logic [7:0]  mac_b_o,
    output logic        mac_valid_in_o,
    input  logic [15:0] mac_f_i,
    input  logic        mac_valid_out_i,

    output logic [15:0] res_f_o,
    output logic        res_id_o,
    output logic        res_valid_o
);

    localparam int CW = $clog2(VEC_LEN + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(VEC_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_FEED  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic           grant_q, grant_d;
    logic [CW-1:0]  in_cnt_q, in_cnt_d;
    logic [CW-1:0]  out_cnt_q, out_cnt_d;
    logic [15:0]    res_f_q, res_f_d;
    logic           res_id_q, res_id_d;
    logic           res_valid_q, res_valid_d;

    logic           grant_pick;
    logic           sel_valid;
    logic           done;

`ifdef MAC_DOT_ARB_FIXED_PRIO_EN
    // Requester 0 wins whenever it is asking; requester 1 only gets idle slots.
    always_comb begin
        grant_pick = ~req0_valid_i;
    end
`else
    logic last_q, last_d;

    // On a tie, grant the requester that was not served last.
    always_comb begin
        if (req0_valid_i && req1_valid_i) begin
            grant_pick = ~last_q;
        end else begin
            grant_pick = req1_valid_i & ~req0_valid_i;
        end
        last_d = done ? grant_q : last_q;
    end

    // Last-granted pointer; starts at 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    assign sel_valid = grant_q ? req1_valid_i : req0_valid_i;

    // Next-state, counter and datapath steering logic.
    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        in_cnt_d       = in_cnt_q;
        out_cnt_d      = out_cnt_q;
        res_f_d        = res_f_q;
        res_id_d       = res_id_q;
        res_valid_d    = 1'b0;
        done           = 1'b0;
        mac_clr_o      = 1'b0;
        req0_ready_o   = 1'b0;
        req1_ready_o   = 1'b0;
        mac_a_o        = 8'd0;
        mac_b_o        = 8'd0;
        mac_valid_in_o = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req0_valid_i || req1_valid_i) begin
                    grant_d   = grant_pick;
                    in_cnt_d  = '0;
                    out_cnt_d = '0;
                    state_d   = S_CLEAR;
                end
            end
            S_CLEAR: begin
                mac_clr_o = 1'b1;
                state_d   = S_FEED;
            end
            S_FEED: begin
                req0_ready_o   = ~grant_q;
                req1_ready_o   = grant_q;
                mac_a_o        = grant_q ? req1_a_i : req0_a_i;
                mac_b_o        = grant_q ? req1_b_i : req0_b_i;
                mac_valid_in_o = sel_valid;
                if (sel_valid) begin
                    in_cnt_d = in_cnt_q + CW'(1);
                    if (in_cnt_q == LAST_IDX) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                state_d = S_DRAIN;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // MAC completions only count once operands can be in flight.
        if ((state_q == S_FEED || state_q == S_DRAIN) && mac_valid_out_i) begin
            if (out_cnt_q == LAST_IDX) begin
                done        = 1'b1;
                res_f_d     = mac_f_i;
                res_id_d    = grant_q;
                res_valid_d = 1'b1;
                out_cnt_d   = out_cnt_q + CW'(1);
                state_d     = S_IDLE;
            end else begin
                out_cnt_d = out_cnt_q + CW'(1);
            end
        end
    end

    // State, counters and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            grant_q     <= 1'b0;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            res_f_q     <= 16'd0;
            res_id_q    <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            in_cnt_q    <= in_cnt_d;
            out_cnt_q   <= out_cnt_d;
            res_f_q     <= res_f_d;
            res_id_q    <= res_id_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign res_f_o     = res_f_q;
    assign res_id_o    = res_id_q;
    assign res_valid_o = res_valid_q;

endmodule

// File: tb/tb_mac_dot_arbiter.sv
// Testbench for mac_dot_arbiter: behavioural 2-stage MAC, per-requester
// operand queues and expected dot products computed with integer arithmetic.
module tb_mac_dot_arbiter;
    localparam int V = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic [7:0]  req0_a, req0_b, req1_a, req1_b;
    logic        req0_ready, req1_ready;
    logic        mac_clr, mac_valid_in;
    logic [7:0]  mac_a, mac_b;
    logic [15:0] mac_f;
    logic        mac_valid_out;
    logic [15:0] res_f;
    logic        res_id, res_valid;

    always #5 clk = ~clk;

    mac_dot_arbiter #(.VEC_LEN(V)) dut (
        .clk(clk), .reset(reset),
        .req0_valid_i(req0_valid), .req0_a_i(req0_a), .req0_b_i(req0_b), .req0_ready_o(req0_ready),
        .req1_valid_i(req1_valid), .req1_a_i(req1_a), .req1_b_i(req1_b), .req1_ready_o(req1_ready),
        .mac_clr_o(mac_clr), .mac_a_o(mac_a), .mac_b_o(mac_b), .mac_valid_in_o(mac_valid_in),
        .mac_f_i(mac_f), .mac_valid_out_i(mac_valid_out),
        .res_f_o(res_f), .res_id_o(res_id), .res_valid_o(res_valid)
    );

    // Behavioural MAC: product stage then accumulate stage, latency 2.
    logic        m_v1, m_vout;
    logic [15:0] m_p1, m_acc;
    always @(posedge clk) begin
        if (reset || mac_clr) begin
            m_v1 <= 1'b0; m_p1 <= 16'd0; m_acc <= 16'd0; m_vout <= 1'b0;
        end else begin
            m_v1   <= mac_valid_in;
            m_p1   <= {{8{mac_a[7]}}, mac_a} * {{8{mac_b[7]}}, mac_b};
            m_vout <= m_v1;
            if (m_v1) m_acc <= m_acc + m_p1;
        end
    end
    assign mac_f = m_acc;
    assign mac_valid_out = m_vout;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0]  qa0[$], qb0[$], qa1[$], qb1[$];
    int          gq0[$], gq1[$];
    logic [15:0] exp0[$], exp1[$];
    logic [7:0]  va[V], vb[V];
    int          vg[V];

    logic [15:0] rf_log[$];
    logic        rid_log[$];
    int          rcyc_log[$], clr_log[$], hs_cyc_log[$];
    int          both_ready_cnt, r1_before_first, first_v_cyc;

    task automatic clear_logs();
        rf_log.delete(); rid_log.delete(); rcyc_log.delete();
        clr_log.delete(); hs_cyc_log.delete();
        exp0.delete(); exp1.delete();
        both_ready_cnt = 0; r1_before_first = 0; first_v_cyc = -1;
    endtask

    task automatic enqueue(input int id);
        int s;
        s = 0;
        for (int i = 0; i < V; i++) begin
            s += int'($signed(va[i])) * int'($signed(vb[i]));
            if (id == 0) begin qa0.push_back(va[i]); qb0.push_back(vb[i]); gq0.push_back(vg[i]); end
            else         begin qa1.push_back(va[i]); qb1.push_back(vb[i]); gq1.push_back(vg[i]); end
        end
        if (id == 0) exp0.push_back(s[15:0]);
        else         exp1.push_back(s[15:0]);
    endtask

    task automatic drive();
        if (qa0.size() > 0) begin
            if (gq0[0] > 0) begin req0_valid = 1'b0; gq0[0] = gq0[0] - 1; end
            else begin req0_valid = 1'b1; req0_a = qa0[0]; req0_b = qb0[0]; end
        end else req0_valid = 1'b0;
        if (!req0_valid) begin req0_a = 8'($urandom); req0_b = 8'($urandom); end
        if (qa1.size() > 0) begin
            if (gq1[0] > 0) begin req1_valid = 1'b0; gq1[0] = gq1[0] - 1; end
            else begin req1_valid = 1'b1; req1_a = qa1[0]; req1_b = qb1[0]; end
        end else req1_valid = 1'b0;
        if (!req1_valid) begin req1_a = 8'($urandom); req1_b = 8'($urandom); end
    endtask

    // One clock: observe at the falling edge, advance drivers after the rising edge.
    task automatic step();
        logic hs0, hs1;
        @(negedge clk);
        cyc++;
        if (res_valid) begin rf_log.push_back(res_f); rid_log.push_back(res_id); rcyc_log.push_back(cyc); end
        if (mac_clr) clr_log.push_back(cyc);
        if (req0_ready && req1_ready) both_ready_cnt++;
        if (req1_ready && rf_log.size() == 0) r1_before_first++;
        if (first_v_cyc < 0 && (req0_valid || req1_valid)) first_v_cyc = cyc;
        hs0 = req0_valid && req0_ready;
        hs1 = req1_valid && req1_ready;
        if (hs0 || hs1) hs_cyc_log.push_back(cyc);
        @(posedge clk); #1;
        if (hs0) begin qa0.delete(0); qb0.delete(0); gq0.delete(0); end
        if (hs1) begin qa1.delete(0); qb1.delete(0); gq1.delete(0); end
        drive();
    endtask

    task automatic run_results(input int n, input int budget);
        int k;
        k = 0;
        while (rf_log.size() < n && k < budget) begin step(); k++; end
        repeat (3) step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (res_valid !== 1'b0)    begin errors++; $display("FAIL rst_res_valid: got %0d expected 0", res_valid); end
        checks++; if (res_f !== 16'd0)       begin errors++; $display("FAIL rst_res_f: got %0d expected 0", res_f); end
        checks++; if (res_id !== 1'b0)       begin errors++; $display("FAIL rst_res_id: got %0d expected 0", res_id); end
        checks++; if (mac_clr !== 1'b0)      begin errors++; $display("FAIL rst_mac_clr: got %0d expected 0", mac_clr); end
        checks++; if (req0_ready !== 1'b0)   begin errors++; $display("FAIL rst_ready0: got %0d expected 0", req0_ready); end
        checks++; if (req1_ready !== 1'b0)   begin errors++; $display("FAIL rst_ready1: got %0d expected 0", req1_ready); end
        checks++; if (mac_valid_in !== 1'b0) begin errors++; $display("FAIL rst_mac_valid_in: got %0d expected 0", mac_valid_in); end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        clear_logs();
        for (int i = 0; i < V; i++) begin va[i] = 8'(i + 1); vb[i] = 8'd2; vg[i] = 0; end
        enqueue(0);
        run_results(1, 40);
        checks++; if (rf_log.size() !== 1) begin errors++; $display("FAIL basic_count: got %0d expected 1", rf_log.size()); end
        if (rf_log.size() >= 1 && clr_log.size() >= 1 && hs_cyc_log.size() >= 1) begin
            checks++; if (rf_log[0] !== 16'd20) begin errors++; $display("FAIL basic_res_f: got %0d expected 20", rf_log[0]); end
            checks++; if (rid_log[0] !== 1'b0) begin errors++; $display("FAIL basic_res_id: got %0d expected 0", rid_log[0]); end
            checks++; if (clr_log[0] !== first_v_cyc + 1) begin errors++; $display("FAIL basic_clr_cycle: got %0d expected %0d", clr_log[0], first_v_cyc + 1); end
            checks++; if (hs_cyc_log[0] !== first_v_cyc + 2) begin errors++; $display("FAIL basic_first_hs: got %0d expected %0d", hs_cyc_log[0], first_v_cyc + 2); end
            checks++; if (rcyc_log[0] !== hs_cyc_log[0] + V + 2) begin errors++; $display("FAIL basic_res_cycle: got %0d expected %0d", rcyc_log[0], hs_cyc_log[0] + V + 2); end
        end
    endtask

    task automatic test_round_robin();
        int exp_ids[4];
`ifdef MAC_DOT_ARB_FIXED_PRIO_EN
        exp_ids = '{0, 0, 1, 1};
`else
        exp_ids = '{0, 1, 0, 1};
`endif
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        clear_logs();
        for (int i = 0; i < V; i++) begin va[i] = 8'(i + 1); vb[i] = 8'd2; vg[i] = 0; end
        enqueue(0); enqueue(1); enqueue(0); enqueue(1);
        run_results(4, 100);
        checks++; if (rf_log.size() !== 4) begin errors++; $display("FAIL rr_count: got %0d expected 4", rf_log.size()); end
        checks++; if (r1_before_first !== 0) begin errors++; $display("FAIL rr_ready1_during_req0: got %0d cycles expected 0", r1_before_first); end
        checks++; if (both_ready_cnt !== 0) begin errors++; $display("FAIL rr_both_ready: got %0d cycles expected 0", both_ready_cnt); end
        for (int i = 0; i < 4 && i < rf_log.size(); i++) begin
            checks++; if (rid_log[i] !== 1'(exp_ids[i])) begin errors++; $display("FAIL rr_id[%0d]: got %0d expected %0d", i, rid_log[i], exp_ids[i]); end
            checks++; if (rf_log[i] !== 16'd20) begin errors++; $display("FAIL rr_res_f[%0d]: got %0d expected 20", i, rf_log[i]); end
            if (i > 0) begin
                checks++; if (rcyc_log[i] - rcyc_log[i-1] !== V + 4) begin errors++; $display("FAIL rr_period[%0d]: got %0d expected %0d", i, rcyc_log[i] - rcyc_log[i-1], V + 4); end
            end
        end
    endtask

    task automatic test_wrap();
        clear_logs();
        for (int i = 0; i < V; i++) begin va[i] = 8'h80; vb[i] = 8'h80; vg[i] = 0; end
        enqueue(0);
        run_results(1, 40);
        checks++; if (rf_log.size() !== 1) begin errors++; $display("FAIL wrap_count: got %0d expected 1", rf_log.size()); end
        if (rf_log.size() >= 1) begin
            checks++; if (rf_log[0] !== 16'd0) begin errors++; $display("FAIL wrap_res_f: got %0d expected 0", rf_log[0]); end
        end
    endtask

    task automatic test_bubbles();
        clear_logs();
        for (int i = 0; i < V; i++) begin va[i] = 8'hFD; vb[i] = 8'd5; vg[i] = (i == 2) ? 2 : 0; end
        enqueue(1);
        run_results(1, 40);
        checks++; if (rf_log.size() !== 1) begin errors++; $display("FAIL bub_count: got %0d expected 1", rf_log.size()); end
        if (rf_log.size() >= 1 && hs_cyc_log.size() >= 1) begin
            checks++; if (rf_log[0] !== 16'hFFC4) begin errors++; $display("FAIL bub_res_f: got %0d expected -60", $signed(rf_log[0])); end
            checks++; if (rid_log[0] !== 1'b1) begin errors++; $display("FAIL bub_res_id: got %0d expected 1", rid_log[0]); end
            checks++; if (rcyc_log[0] - hs_cyc_log[0] !== V + 4) begin errors++; $display("FAIL bub_latency: got %0d expected %0d", rcyc_log[0] - hs_cyc_log[0], V + 4); end
        end
    endtask

    task automatic test_reset_mid();
        int k;
        clear_logs();
        for (int i = 0; i < V; i++) begin va[i] = 8'(i + 5); vb[i] = 8'd1; vg[i] = 0; end
        enqueue(0);
        k = 0;
        while (hs_cyc_log.size() < 2 && k < 40) begin step(); k++; end
        checks++; if (hs_cyc_log.size() !== 2) begin errors++; $display("FAIL rm_handshakes: got %0d expected 2", hs_cyc_log.size()); end
        reset = 1'b1;
        qa0.delete(); qb0.delete(); gq0.delete(); exp0.delete();
        step(); step();
        checks++; if (res_f !== 16'd0)     begin errors++; $display("FAIL rm_res_f: got %0d expected 0", res_f); end
        checks++; if (res_id !== 1'b0)     begin errors++; $display("FAIL rm_res_id: got %0d expected 0", res_id); end
        checks++; if (res_valid !== 1'b0)  begin errors++; $display("FAIL rm_res_valid: got %0d expected 0", res_valid); end
        checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL rm_ready0: got %0d expected 0", req0_ready); end
        checks++; if (mac_clr !== 1'b0)    begin errors++; $display("FAIL rm_mac_clr: got %0d expected 0", mac_clr); end
        reset = 1'b0;
        clear_logs();
        for (int i = 0; i < V; i++) begin va[i] = 8'd1; vb[i] = 8'd1; vg[i] = 0; end
        enqueue(0);
        run_results(1, 40);
        checks++; if (rf_log.size() !== 1) begin errors++; $display("FAIL rm_count: got %0d expected 1", rf_log.size()); end
        if (rf_log.size() >= 1) begin
            checks++; if (rf_log[0] !== 16'd4) begin errors++; $display("FAIL rm_res_f: got %0d expected 4", rf_log[0]); end
            checks++; if (rid_log[0] !== 1'b0) begin errors++; $display("FAIL rm_res_id: got %0d expected 0", rid_log[0]); end
        end
    endtask

    task automatic test_random();
        int n;
        logic [15:0] e;
        n = 24;
        clear_logs();
        for (int t = 0; t < n; t++) begin
            for (int i = 0; i < V; i++) begin
                va[i] = 8'($urandom); vb[i] = 8'($urandom); vg[i] = $urandom_range(0, 2);
            end
            enqueue($urandom_range(0, 1));
        end
        run_results(n, n * 40);
        checks++; if (rf_log.size() !== n) begin errors++; $display("FAIL rnd_count: got %0d expected %0d", rf_log.size(), n); end
        checks++; if (both_ready_cnt !== 0) begin errors++; $display("FAIL rnd_both_ready: got %0d cycles expected 0", both_ready_cnt); end
        for (int i = 0; i < rf_log.size(); i++) begin
            checks++;
            if (rid_log[i] === 1'b0 && exp0.size() > 0) begin
                e = exp0.pop_front();
                if (rf_log[i] !== e) begin errors++; $display("FAIL rnd_res_f[%0d] id0: got %0h expected %0h", i, rf_log[i], e); end
            end else if (rid_log[i] === 1'b1 && exp1.size() > 0) begin
                e = exp1.pop_front();
                if (rf_log[i] !== e) begin errors++; $display("FAIL rnd_res_f[%0d] id1: got %0h expected %0h", i, rf_log[i], e); end
            end else begin
                errors++; $display("FAIL rnd_unexpected[%0d]: got id %0d with no pending vector expected none", i, rid_log[i]);
            end
        end
        checks++; if (exp0.size() + exp1.size() !== 0) begin errors++; $display("FAIL rnd_leftover: got %0d unreturned expected 0", exp0.size() + exp1.size()); end
    endtask

    initial begin
        reset = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = 8'd0; req0_b = 8'd0; req1_a = 8'd0; req1_b = 8'd0;
        clear_logs();
        test_reset();
        test_basic();
        test_round_robin();
        test_wrap();
        test_bubbles();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
